wr_ctrl: RTL and testbench

Write-side controller for the double-buffered reorder FIFO. It steers tagged incoming entries into bank 0 or bank 1 and tracks which reorder slots of the active bank are filled. When every slot is filled it locks the bank for the read-side state machine, then moves to the other bank. It releases a lock when the reader reports that bank drained, and enforces strict bank alternation so output order is preserved.

---
 rtl/dbrf_pkg.sv | 22 ++
 rtl/wr_ctrl_if.sv | 38 +++
 rtl/wr_bank_tracker.sv | 69 ++++++
 rtl/wr_ctrl.sv | 112 +++++++++++
 tb/tb_wr_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/dbrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbrf_pkg
//  Description : Shared types for the double-buffered reorder FIFO. Holds the
//                one-hot write-side state encoding and its bit indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbrf_pkg;

    // One-hot write-side states; bit indices below address them directly
    typedef enum logic [2:0] {
        WR0    = 3'b001,
        WR1    = 3'b010,
        WRWAIT = 3'b100
    } wr_state_t;

    localparam int WR0_BIT    = 0;
    localparam int WR1_BIT    = 1;
    localparam int WRWAIT_BIT = 2;

endpackage
`default_nettype wire

// File: rtl/wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : wr_ctrl_if
//  Description : Bundle between the upstream writer/reader side (master) and
//                the write-side controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wr_ctrl_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          in_valid;
    logic [AW-1:0] in_tag;
    logic          in_ready;
    logic          mem0_we;
    logic          mem1_we;
    logic [AW-1:0] mem_waddr;
    logic          mem0_lock;
    logic          mem1_lock;
    logic          mem0_drained;
    logic          mem1_drained;
    logic          dup_err;

    modport master (
        output in_valid, in_tag, mem0_drained, mem1_drained,
        input  in_ready, mem0_we, mem1_we, mem_waddr,
               mem0_lock, mem1_lock, dup_err
    );

    modport slave (
        input  in_valid, in_tag, mem0_drained, mem1_drained,
        output in_ready, mem0_we, mem1_we, mem_waddr,
               mem0_lock, mem1_lock, dup_err
    );

endinterface
`default_nettype wire

// File: rtl/wr_bank_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : wr_bank_tracker
//  Description : Per-bank fill bitmap, lock flag, completion detect and
//                duplicate-tag detection. Duplicate suppression is enabled by
//                the WR_CTRL_DUP_CHECK_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_bank_tracker
    import dbrf_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,     // accept while this bank is active
    input  logic [AW-1:0] tag,
    input  logic          drained,
    output logic          we,
    output logic          lock,
    output logic          complete,
    output logic          dup
);

    logic [DEPTH-1:0] bitmap;
    logic [DEPTH-1:0] mask;
    logic [DEPTH-1:0] next_map;
    logic             hit;
    logic             set;

    // Slot mask, post-accept bitmap and completion detect
    always_comb begin
        mask      = '0;
        mask[tag] = 1'b1;
        hit       = bitmap[tag];
        // A repeated tag never touches the bitmap, so it cannot fake completion
        set       = wr_en && !hit;
        next_map  = set ? (bitmap | mask) : bitmap;
        complete  = set && (&next_map);
`ifdef WR_CTRL_DUP_CHECK_EN
        we        = wr_en && !hit;
        dup       = wr_en && hit;
`else
        we        = wr_en;
        dup       = 1'b0;
`endif
    end

    // Bitmap and lock: completion locks and clears; a drain releases the lock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap <= '0;
            lock   <= 1'b0;
        end else begin
            if (complete) begin
                bitmap <= '0;
                lock   <= 1'b1;
            end else begin
                bitmap <= next_map;
                if (drained) begin
                    lock <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wr_ctrl
//  Description : Write-side controller of the double-buffered reorder FIFO.
//                Steers tagged entries into the active bank, locks a bank when
//                every slot is filled and alternates strictly between banks.
//                Optional macro: WR_CTRL_DUP_CHECK_EN (duplicate-tag drop and
//                dup_err reporting).
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_ctrl
    import dbrf_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    wr_ctrl_if.slave   bus
);

    wr_state_t  state;
    logic       nxt_bank;
    logic       in_ready;
    logic       accept;
    logic [1:0] wr_en;
    logic [1:0] we;
    logic [1:0] lock;
    logic [1:0] complete;
    logic [1:0] dup;
    logic [1:0] drained;
    logic [1:0] free;
    logic       dup_err;

    // Handshake, per-bank write enables and bank availability
    always_comb begin
        in_ready = state[WR0_BIT] | state[WR1_BIT];
        accept   = bus.in_valid && in_ready;
        wr_en[0] = accept && state[WR0_BIT];
        wr_en[1] = accept && state[WR1_BIT];
        drained  = {bus.mem1_drained, bus.mem0_drained};
        // A drain pulse frees the bank in the very cycle it arrives
        free     = ~lock | drained;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        wr_bank_tracker #(
            .DEPTH    (DEPTH)
        ) u_tracker (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[b]),
            .tag      (bus.in_tag),
            .drained  (drained[b]),
            .we       (we[b]),
            .lock     (lock[b]),
            .complete (complete[b]),
            .dup      (dup[b])
        );
    end

    // Bank-select state machine; WRWAIT only ever resumes into nxt_bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WR0;
            nxt_bank <= 1'b0;
        end else begin
            unique case (state)
                WR0: begin
                    if (complete[0]) begin
                        nxt_bank <= 1'b1;
                        state    <= free[1] ? WR1 : WRWAIT;
                    end
                end
                WR1: begin
                    if (complete[1]) begin
                        nxt_bank <= 1'b0;
                        state    <= free[0] ? WR0 : WRWAIT;
                    end
                end
                WRWAIT: begin
                    if (!nxt_bank && free[0]) begin
                        state <= WR0;
                    end else if (nxt_bank && free[1]) begin
                        state <= WR1;
                    end
                end
                default: begin
                    state <= WR0;
                end
            endcase
        end
    end

    // Duplicate report, one cycle after the offending accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dup_err <= 1'b0;
        end else begin
            dup_err <= |dup;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem0_we   = we[0];
    assign bus.mem1_we   = we[1];
    assign bus.mem_waddr = bus.in_tag;
    assign bus.mem0_lock = lock[0];
    assign bus.mem1_lock = lock[1];
    assign bus.dup_err   = dup_err;

endmodule
`default_nettype wire

// File: tb/tb_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wr_ctrl
//  Description : Directed, table-driven bench for wr_ctrl with DEPTH=4.
//                Expectations for duplicates follow WR_CTRL_DUP_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_ctrl;
    import dbrf_pkg::*;

`ifdef WR_CTRL_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    // exp = {in_ready, mem0_we, mem1_we, mem0_lock, mem1_lock, dup_err}
    // st  = expected one-hot state, 0 = not checked
    typedef struct {
        bit         chk;
        bit         rn;
        bit         v;
        logic [1:0] tag;
        bit         d0;
        bit         d1;
        logic [5:0] exp;
        logic [2:0] st;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    wr_ctrl_if #(.DEPTH(4)) bus();

    wr_ctrl #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit chk, bit rn, bit v, int tag, bit d0, bit d1,
                                logic [5:0] exp, logic [2:0] st);
        vec_t t;
        t.chk = chk; t.rn = rn; t.v = v; t.tag = 2'(tag);
        t.d0 = d0; t.d1 = d1; t.exp = exp; t.st = st;
        return t;
    endfunction

    // Drive one cycle of inputs after the falling edge, then compare outputs
    task automatic apply(input vec_t t, input string nm, input int idx);
        logic [7:0] got;
        logic [7:0] exp;
        @(negedge clk);
        rst_n            = t.rn;
        bus.in_valid     = t.v;
        bus.in_tag       = t.tag;
        bus.mem0_drained = t.d0;
        bus.mem1_drained = t.d1;
        #1;
        if (t.chk) begin
            got = {bus.mem_waddr, bus.in_ready, bus.mem0_we, bus.mem1_we,
                   bus.mem0_lock, bus.mem1_lock, bus.dup_err};
            exp = {t.tag, t.exp};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s[%0d] {waddr,rdy,we0,we1,lk0,lk1,dup}: got %b required %b",
                         nm, idx, got, exp);
            end
            if (t.st != 3'b000) begin
                checks++;
                if (dut.state !== t.st) begin
                    errors++;
                    $display("FAIL %s[%0d] state: got %b required %b",
                             nm, idx, dut.state, t.st);
                end
            end
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_tag       = '0;
        bus.mem0_drained = 1'b0;
        bus.mem1_drained = 1'b0;

        // Reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000000, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000000, 3'b000));
        // Fill bank 0 out of order: 3,1,0,2
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b110000, WR0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 6'b110000, 3'b000));
        // Bank 0 locked, now in WR1 with no bubble; fill bank 1
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b101100, WR1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b101100, 3'b000));
        // Both locked: WRWAIT; bank-1 drain does not release the wait
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 6'b000110, WRWAIT));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b000100, WRWAIT));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 6'b000100, WRWAIT));
        // Back in WR0, fill bank 0 (bank 1 free -> WR1)
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b110000, WR0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b110000, 3'b000));
        // Fill bank 1 while bank 0 is locked -> WRWAIT
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b101100, WR1));
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b101100, 3'b000));
        // Drain bank 0 in the wait: that cycle is the switch cycle
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 6'b000110, WRWAIT));
        // Fill bank 0; last accept coincides with bank-1 drain
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b110010, WR0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b110010, 3'b000));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b110010, 3'b000));
        vecs.push_back(mk(1, 1, 1, 2, 0, 1, 6'b110010, 3'b000));
        // No bubble into WR1, bank 1 unlocked
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b101100, WR1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b101100, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 6'b000110, WRWAIT));
        // Bank 0 half full, bank 1 locked, then reset
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b110010, WR0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b110010, 3'b000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 6'b000000, 3'b000));
        // Fresh fill after reset; stale bits would complete early
        vecs.push_back(mk(1, 1, 1, 2, 0, 0, 6'b110000, WR0));
        vecs.push_back(mk(1, 1, 1, 3, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 6'b110000, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 6'b100100, WR1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], "table", i);
        end

        // Duplicate-tag sequence on a freshly reset controller
        apply(mk(0, 0, 0, 0, 0, 0, 6'b000000, 3'b000), "dup", 0);
        apply(mk(1, 1, 1, 2, 0, 0, 6'b110000, WR0), "dup", 1);
        apply(mk(1, 1, 1, 2, 0, 0, {1'b1, !DUP, 4'b0000}, 3'b000), "dup", 2);
        apply(mk(1, 1, 1, 0, 0, 0, {5'b11000, DUP}, 3'b000), "dup", 3);
        apply(mk(1, 1, 1, 1, 0, 0, 6'b110000, 3'b000), "dup", 4);
        apply(mk(1, 1, 1, 3, 0, 0, 6'b110000, WR0), "dup", 5);
        apply(mk(1, 1, 0, 0, 0, 0, 6'b100100, WR1), "dup", 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
